seq_state_decoder: RTL and testbench

//  Receive-side companion of the 2-bit sequence generators. It watches the generator's

---
 rtl/seq_state_decoder.sv | 146 ++++++++++++++
 tb/tb_seq_state_decoder.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_state_decoder.sv
// Observes a 2-bit sequence generator's state stream, recovers the driving input bit,
// checks step legality, locks onto the stream and keeps saturating advance/error counts.
module seq_state_decoder #(
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CNT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    input  logic [1:0]       state_in,
    output logic             x_out,
    output logic             x_valid,
    output logic             locked,
    output logic             err,
    output logic [CNT_W-1:0] adv_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned LC_W = (LOCK_CNT < 2) ? 1 : $clog2(LOCK_CNT + 1);
    localparam logic [LC_W-1:0]  LOCK_MAX = LC_W'(LOCK_CNT);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACQ    = 2'd1,
        S_LOCKED = 2'd2
    } state_t;

    state_t           r_state;
    logic [1:0]       r_prev;
    logic             r_mode_q;
    logic [LC_W-1:0]  r_lock_cnt;
    logic             r_x_out;
    logic             r_x_valid;
    logic             r_locked;
    logic             r_err;
    logic [CNT_W-1:0] r_adv_cnt;
    logic [CNT_W-1:0] r_err_cnt;

    logic [1:0]       w_succ;
    logic             w_hold;
    logic             w_adv;
    logic             w_legal;
    logic             w_mode_chg;
    logic [LC_W-1:0]  w_lc_inc;
    logic [CNT_W-1:0] w_adv_next;
    logic [CNT_W-1:0] w_err_next;

    // Expected successor of the previous sample for the selected order.
    always_comb begin
        w_succ = 2'd0;
        case ({mode, r_prev})
            3'b0_00: w_succ = 2'd2;
            3'b0_10: w_succ = 2'd3;
            3'b0_11: w_succ = 2'd1;
            3'b0_01: w_succ = 2'd0;
            3'b1_00: w_succ = 2'd3;
            3'b1_11: w_succ = 2'd2;
            3'b1_10: w_succ = 2'd1;
            3'b1_01: w_succ = 2'd0;
            default: w_succ = 2'd0;
        endcase
    end

    assign w_hold     = (state_in == r_prev);
    assign w_adv      = (state_in == w_succ);
    assign w_legal    = w_hold | w_adv;
    assign w_mode_chg = (mode != r_mode_q) && (r_state != S_IDLE);
    assign w_lc_inc   = r_lock_cnt + LC_W'(1);
    assign w_adv_next = (r_adv_cnt == CNT_MAX) ? r_adv_cnt : r_adv_cnt + CNT_W'(1);
    assign w_err_next = (r_err_cnt == CNT_MAX) ? r_err_cnt : r_err_cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_prev     <= 2'd0;
            r_mode_q   <= mode;
            r_lock_cnt <= '0;
            r_x_out    <= 1'b0;
            r_x_valid  <= 1'b0;
            r_locked   <= 1'b0;
            r_err      <= 1'b0;
            r_adv_cnt  <= '0;
            r_err_cnt  <= '0;
        end else begin
            r_mode_q  <= mode;
            r_x_valid <= 1'b0;
            r_err     <= 1'b0;
            if (w_mode_chg) begin
                // Order changed under us: drop lock and re-acquire, ignoring this sample.
                r_state    <= S_IDLE;
                r_locked   <= 1'b0;
                r_lock_cnt <= '0;
            end else if (in_valid) begin
                r_prev <= state_in;
                case (r_state)
                    S_IDLE: begin
                        r_state    <= S_ACQ;
                        r_lock_cnt <= '0;
                    end
                    S_ACQ: begin
                        if (w_legal) begin
                            r_x_valid  <= 1'b1;
                            r_x_out    <= w_adv;
                            r_lock_cnt <= w_lc_inc;
                            if (w_adv) r_adv_cnt <= w_adv_next;
                            if (w_lc_inc >= LOCK_MAX) begin
                                r_state  <= S_LOCKED;
                                r_locked <= 1'b1;
                            end
                        end else begin
                            r_lock_cnt <= '0;
                        end
                    end
                    S_LOCKED: begin
                        if (w_legal) begin
                            r_x_valid <= 1'b1;
                            r_x_out   <= w_adv;
                            if (w_adv) r_adv_cnt <= w_adv_next;
                        end else begin
                            r_err      <= 1'b1;
                            r_err_cnt  <= w_err_next;
                            r_locked   <= 1'b0;
                            r_state    <= S_ACQ;
                            r_lock_cnt <= '0;
                        end
                    end
                    default: begin
                        r_state    <= S_IDLE;
                        r_locked   <= 1'b0;
                        r_lock_cnt <= '0;
                    end
                endcase
            end
        end
    end

    assign x_out   = r_x_out;
    assign x_valid = r_x_valid;
    assign locked  = r_locked;
    assign err     = r_err;
    assign adv_cnt = r_adv_cnt;
    assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_seq_state_decoder.sv
// Scoreboard bench for seq_state_decoder: directed scenarios plus random generator-like
// streams, checked against a rule-level reference model (default and CNT_W=3 instances).
module tb_seq_state_decoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic       in_valid;
    logic [1:0] state_in;

    logic       x_out, x_valid, locked, err;
    logic [7:0] adv_cnt, err_cnt;
    logic       x_out3, x_valid3, locked3, err3;
    logic [2:0] adv_cnt3, err_cnt3;

    always #5 clk = ~clk;

    seq_state_decoder dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .state_in(state_in),
        .x_out(x_out), .x_valid(x_valid), .locked(locked), .err(err),
        .adv_cnt(adv_cnt), .err_cnt(err_cnt)
    );

    seq_state_decoder #(.CNT_W(3), .LOCK_CNT(2)) dut3 (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .state_in(state_in),
        .x_out(x_out3), .x_valid(x_valid3), .locked(locked3), .err(err3),
        .adv_cnt(adv_cnt3), .err_cnt(err_cnt3)
    );

    typedef struct {
        int tag;
        bit xv;
        bit x;
        bit e;
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   edge_cnt = 0;
    bit   chk_en = 1'b0;

    // Generator orders: index 0 is mode 0, index 1 is mode 1.
    int ord[2][4] = '{'{0, 2, 3, 1}, '{0, 3, 2, 1}};

    bit m_idle, m_lk, m_xo, m_mq;
    int m_prev, m_streak, m_adv, m_ec, m_adv3, m_ec3;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    function automatic int succ(input int p, input bit md);
        for (int i = 0; i < 4; i++)
            if (ord[md][i] == p) return ord[md][(i + 1) % 4];
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp_v, $time);
        end
    endtask

    task automatic model_edge(input bit r, input bit md, input bit v, input int s);
        bit   xv, er, xa, chg;
        exp_t e;
        xv = 1'b0; er = 1'b0; xa = 1'b0;
        if (r) begin
            m_idle = 1'b1; m_prev = 0; m_streak = 0; m_lk = 1'b0; m_xo = 1'b0;
            m_adv = 0; m_ec = 0; m_adv3 = 0; m_ec3 = 0; m_mq = md;
        end else begin
            chg  = (md != m_mq) && !m_idle;
            m_mq = md;
            if (chg) begin
                m_idle = 1'b1; m_lk = 1'b0; m_streak = 0;
            end else if (v) begin
                if (m_idle) begin
                    m_idle = 1'b0; m_streak = 0;
                end else if (s == m_prev || s == succ(m_prev, md)) begin
                    xv = 1'b1;
                    xa = (s != m_prev);
                    m_xo = xa;
                    if (xa) begin
                        m_adv  = (m_adv < 255) ? m_adv + 1 : 255;
                        m_adv3 = (m_adv3 < 7) ? m_adv3 + 1 : 7;
                    end
                    if (!m_lk) begin
                        m_streak++;
                        if (m_streak >= 2) m_lk = 1'b1;
                    end
                end else begin
                    if (m_lk) begin
                        er = 1'b1;
                        m_ec  = (m_ec < 255) ? m_ec + 1 : 255;
                        m_ec3 = (m_ec3 < 7) ? m_ec3 + 1 : 7;
                    end
                    m_lk = 1'b0;
                    m_streak = 0;
                end
                m_prev = s;
            end
        end
        if (xv || er) begin
            e.tag = edge_cnt + 1; e.xv = xv; e.x = xa; e.e = er;
            q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        chk("locked", 32'(locked), 32'(m_lk));
        chk("x_out", 32'(x_out), 32'(m_xo));
        chk("adv_cnt", 32'(adv_cnt), 32'(m_adv));
        chk("err_cnt", 32'(err_cnt), 32'(m_ec));
        chk("locked3", 32'(locked3), 32'(m_lk));
        chk("adv_cnt3", 32'(adv_cnt3), 32'(m_adv3));
        chk("err_cnt3", 32'(err_cnt3), 32'(m_ec3));
    endtask

    // One clock of stimulus: verify the outputs of the previous edge, then apply new inputs.
    task automatic drive(input bit r, input bit md, input bit v, input int s);
        @(negedge clk);
        if (chk_en) check_outputs();
        rst = r; mode = md; in_valid = v; state_in = 2'(s);
        model_edge(r, md, v, s);
        if (r) chk_en = 1'b1;
    endtask

    task automatic samples(input bit md, input int n, input int s0, input int s1, input int s2,
                           input int s3, input int s4, input int s5);
        int arr[6];
        arr = '{s0, s1, s2, s3, s4, s5};
        for (int i = 0; i < n; i++) drive(1'b0, md, 1'b1, arr[i]);
    endtask

    // Monitor: pops the scoreboard whenever a pulse is presented or one is due.
    always @(negedge clk) begin
        if (chk_en) begin
            bit pulse, due;
            exp_t e;
            pulse = (x_valid === 1'b1) || (err === 1'b1);
            due   = (q.size() > 0) && (q[0].tag == edge_cnt);
            if (due) begin
                e = q.pop_front();
                chk("x_valid", 32'(x_valid), 32'(e.xv));
                chk("err", 32'(err), 32'(e.e));
                if (e.xv) chk("x_out_pulse", 32'(x_out), 32'(e.x));
                chk("x_valid3", 32'(x_valid3), 32'(e.xv));
                chk("err3", 32'(err3), 32'(e.e));
            end else if (pulse) begin
                chk("spurious_pulse", 32'({x_valid, err}), 32'd0);
            end
        end
    end

    initial begin
        int p, ill, gen, k;
        bit md, r, v;
        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; state_in = 2'd0;

        // Basic mode-0 decode and lock
        drive(1, 0, 0, 0); drive(1, 0, 0, 0);
        samples(0, 6, 0, 0, 2, 3, 1, 0);
        drive(0, 0, 0, 0);
        chk("t1_adv", 32'(adv_cnt), 32'd4);
        chk("t1_locked", 32'(locked), 32'd1);

        // Mode-1 order, then the same stream decoded as mode 0
        drive(1, 1, 0, 0);
        samples(1, 5, 0, 3, 2, 1, 0, 0);
        drive(0, 1, 0, 0);
        chk("t2_adv_m1", 32'(adv_cnt), 32'd4);
        drive(1, 0, 0, 0);
        samples(0, 5, 0, 3, 2, 1, 0, 0);
        drive(0, 0, 0, 0);
        chk("t2_adv_m0", 32'(adv_cnt), 32'd1);
        chk("t2_err_m0", 32'(err_cnt), 32'd0);

        // Lock loss and re-lock
        drive(1, 0, 0, 0);
        samples(0, 6, 0, 0, 2, 3, 1, 0);
        samples(0, 1, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t3_err_cnt", 32'(err_cnt), 32'd1);
        chk("t3_unlocked", 32'(locked), 32'd0);
        samples(0, 2, 1, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t3_relocked", 32'(locked), 32'd1);

        // Gap in in_valid
        drive(1, 0, 0, 0);
        samples(0, 3, 0, 0, 2, 0, 0, 0);
        drive(0, 0, 0, 3); drive(0, 0, 0, 1); drive(0, 0, 0, 0);
        samples(0, 1, 3, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t4_x_out", 32'(x_out), 32'd1);
        chk("t4_adv", 32'(adv_cnt), 32'd2);

        // Counter saturation in the narrow instance
        drive(1, 0, 0, 0);
        samples(0, 1, 0, 0, 0, 0, 0, 0);
        samples(0, 6, 2, 3, 1, 0, 2, 3);
        samples(0, 3, 1, 0, 2, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t5_adv3_sat", 32'(adv_cnt3), 32'd7);
        chk("t5_adv9", 32'(adv_cnt), 32'd9);
        p = 2;
        for (int i = 0; i < 9; i++) begin
            ill = 0;
            for (int c = 3; c >= 0; c--) if (c != p && c != succ(p, 0)) ill = c;
            drive(0, 0, 1, ill); drive(0, 0, 1, ill); drive(0, 0, 1, ill);
            p = ill;
        end
        drive(0, 0, 0, 0);
        chk("t5_err3_sat", 32'(err_cnt3), 32'd7);
        chk("t5_err9", 32'(err_cnt), 32'd9);

        // Reset while locked, with a sample present
        drive(1, 0, 1, 1);
        drive(0, 0, 0, 0);
        chk("t6_locked", 32'(locked), 32'd0);
        chk("t6_adv", 32'(adv_cnt), 32'd0);
        chk("t6_x_out", 32'(x_out), 32'd0);
        samples(0, 2, 2, 3, 0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("t6_adv_after", 32'(adv_cnt), 32'd1);

        // Mode change while locked
        drive(1, 0, 0, 0);
        samples(0, 3, 0, 0, 2, 0, 0, 0);
        drive(0, 1, 1, 3);
        drive(0, 1, 0, 0);
        chk("mc_unlocked", 32'(locked), 32'd0);
        samples(1, 2, 3, 2, 0, 0, 0, 0);
        drive(0, 1, 0, 0);
        chk("mc_adv", 32'(adv_cnt), 32'd2);

        // Random generator-like streams with corruption, gaps, mode flips and resets
        gen = 0; md = 1'b0;
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3000; i++) begin
            r = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 149) == 0) md = ~md;
            v = ($urandom_range(0, 3) != 0);
            k = $urandom_range(0, 9);
            if (v) begin
                if (k >= 3 && k < 8) gen = succ(gen, md);
                else if (k >= 8) gen = $urandom_range(0, 3);
                drive(r, md, v, gen);
            end else begin
                drive(r, md, v, $urandom_range(0, 3));
            end
        end

        drive(0, md, 0, 0); drive(0, md, 0, 0); drive(0, md, 0, 0);
        chk("queue_drained", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
